// File: rtl/wb_trace_buffer_if.sv
// Bundle of capture, trigger and read-port signals for wb_trace_buffer.
// master = producer/consumer side (core tap + drain logic), slave = trace buffer.
interface wb_trace_buffer_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   // capture side
   logic          arm;
   logic [31:0]   pc_in;
   logic [31:0]   wdata_in;
   logic          wb_valid;
   logic          trig_en;
   logic [31:0]   trig_pc;
   // read side
   logic          rd_ready;
   logic          rd_valid;
   logic [31:0]   rd_pc;
   logic [31:0]   rd_data;
   // status
   logic [CW-1:0] count;
   logic          overflow;
   logic [1:0]    state;

   modport master (
      output arm, pc_in, wdata_in, wb_valid, trig_en, trig_pc, rd_ready,
      input  rd_valid, rd_pc, rd_data, count, overflow, state
   );

   modport slave (
      input  arm, pc_in, wdata_in, wb_valid, trig_en, trig_pc, rd_ready,
      output rd_valid, rd_pc, rd_data, count, overflow, state
   );
endinterface

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures {PC, write-back data} pairs on each committed
// write-back into a first-word-fall-through FIFO, with a PC-match trigger
// followed by POST_TRIG further captures.
// Optional: define TRACE_DEDUP_EN to suppress back-to-back events that
// repeat the previous PC (pipeline stalls holding the PC).
module wb_trace_buffer #(
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4
) (
   input logic            Clk,
   input logic            Rst,
   wb_trace_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (POST_TRIG < 1) ? 1 : $clog2(POST_TRIG + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      POST    = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t        st;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;
   logic          ovf;
   logic [PW-1:0] post_cnt;

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];

   logic wev, dup, ev, pop, full, push, drop, trig_hit, arm_ok, rd_vld;

`ifdef TRACE_DEDUP_EN
   logic [31:0] last_pc;
   logic        last_vld;

   // Track the PC of the last processed event; an accepted arm forgets it.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         last_pc  <= '0;
         last_vld <= 1'b0;
      end else if (arm_ok) begin
         last_vld <= 1'b0;
      end else if (ev) begin
         last_pc  <= bus.pc_in;
         last_vld <= 1'b1;
      end
   end

   assign dup = last_vld && (bus.pc_in == last_pc);
`else
   assign dup = 1'b0;
`endif

   // Event qualification, FIFO push/pop decisions and trigger match.
   always_comb begin
      rd_vld   = (cnt != '0);
      full     = (cnt == CW'(DEPTH));
      pop      = rd_vld && bus.rd_ready;
      wev      = bus.wb_valid && ((st == CAPTURE) || (st == POST));
      ev       = wev && !dup;
      // a full FIFO still accepts a write when the head leaves in the same edge
      push     = ev && (!full || pop);
      drop     = ev && full && !pop;
      trig_hit = ev && (st == CAPTURE) && bus.trig_en && (bus.pc_in == bus.trig_pc);
      // arm is ignored while counting down post-trigger events
      arm_ok   = bus.arm && (st != POST);
   end

   // Capture state machine, post-trigger countdown and sticky overflow.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         st       <= IDLE;
         post_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         // a drop in the same cycle as a re-arm wins: the loss is reported
         if (arm_ok) ovf <= 1'b0;
         if (drop)   ovf <= 1'b1;
         case (st)
            IDLE: begin
               if (bus.arm) st <= CAPTURE;
            end
            CAPTURE: begin
               if (bus.arm) begin
                  st <= CAPTURE;
               end else if (trig_hit) begin
                  post_cnt <= PW'(POST_TRIG);
                  st       <= (POST_TRIG == 0) ? DONE : POST;
               end
            end
            POST: begin
               if (ev) begin
                  post_cnt <= post_cnt - PW'(1);
                  if (post_cnt == PW'(1)) st <= DONE;
               end
            end
            DONE: begin
               if (bus.arm) st <= CAPTURE;
            end
            default: st <= IDLE;
         endcase
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, the read mux masks them.
   always_ff @(posedge Clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= bus.pc_in;
         data_mem[wr_ptr] <= bus.wdata_in;
      end
   end

   assign bus.rd_valid = rd_vld;
   assign bus.rd_pc    = rd_vld ? pc_mem[rd_ptr]   : 32'h0;
   assign bus.rd_data  = rd_vld ? data_mem[rd_ptr] : 32'h0;
   assign bus.count    = cnt;
   assign bus.overflow = ovf;
   assign bus.state    = st;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed, table-driven bench for wb_trace_buffer (DEPTH=16, POST_TRIG=4).
module tb_wb_trace_buffer;
   localparam int DEPTH = 16;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   wb_trace_buffer_if #(.DEPTH(DEPTH)) bus ();
   wb_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(4)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

   typedef struct {
      logic        arm;
      logic        wbv;
      logic [31:0] pc;
      logic [31:0] data;
      logic        trig_en;
      logic [31:0] trig_pc;
      logic        rdy;
      int          cnt;
      logic        vld;
      logic [31:0] epc;
      logic [31:0] edata;
      logic        ovf;
      logic [1:0]  st;
   } vec_t;

   vec_t tbl[$];
   int checks = 0;
   int errors = 0;

   function automatic vec_t mk(logic arm, logic wbv, logic [31:0] pc, logic [31:0] data,
                               logic te, logic [31:0] tpc, logic rdy, int cnt, logic vld,
                               logic [31:0] epc, logic [31:0] edata, logic ovf, logic [1:0] st);
      vec_t v;
      v.arm = arm; v.wbv = wbv; v.pc = pc; v.data = data; v.trig_en = te; v.trig_pc = tpc;
      v.rdy = rdy; v.cnt = cnt; v.vld = vld; v.epc = epc; v.edata = edata; v.ovf = ovf; v.st = st;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // drive one cycle of inputs, clock it, and sample 1 time unit after the edge
   task automatic cyc(input logic arm, input logic wbv, input logic [31:0] pc,
                      input logic [31:0] data, input logic rdy);
      bus.arm = arm; bus.wb_valid = wbv; bus.pc_in = pc; bus.wdata_in = data; bus.rd_ready = rdy;
      @(posedge Clk); #1;
      bus.arm = 1'b0; bus.wb_valid = 1'b0; bus.rd_ready = 1'b0;
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         bus.trig_en = tbl[i].trig_en;
         bus.trig_pc = tbl[i].trig_pc;
         cyc(tbl[i].arm, tbl[i].wbv, tbl[i].pc, tbl[i].data, tbl[i].rdy);
         chk($sformatf("row%0d count", i), 32'(bus.count), 32'(tbl[i].cnt));
         chk($sformatf("row%0d rd_valid", i), 32'(bus.rd_valid), 32'(tbl[i].vld));
         chk($sformatf("row%0d rd_pc", i), bus.rd_pc, tbl[i].epc);
         chk($sformatf("row%0d rd_data", i), bus.rd_data, tbl[i].edata);
         chk($sformatf("row%0d overflow", i), 32'(bus.overflow), 32'(tbl[i].ovf));
         chk($sformatf("row%0d state", i), 32'(bus.state), 32'(tbl[i].st));
      end
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 40 && bus.count != 0; k++) cyc(0, 0, 0, 0, 1);
      chk(nm, 32'(bus.count), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_basic;
      int n_trig;
      int exp_dd;
      logic [1:0] tst;

      // basic write / FWFT read sequence
      tbl.push_back(mk(1, 0, 0,     0,     0, 0, 0, 0, 0, 0, 0,     0, 2'd1));
      tbl.push_back(mk(0, 1, 32'h0, 32'h11, 0, 0, 0, 1, 1, 0, 32'h11, 0, 2'd1));
      tbl.push_back(mk(0, 1, 32'h4, 32'h22, 0, 0, 0, 2, 1, 0, 32'h11, 0, 2'd1));
      tbl.push_back(mk(0, 1, 32'h8, 32'h33, 0, 0, 0, 3, 1, 0, 32'h11, 0, 2'd1));
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 1, 2, 1, 32'h4, 32'h22, 0, 2'd1));
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 1, 1, 1, 32'h8, 32'h33, 0, 2'd1));
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 1, 0, 0, 0, 0,     0, 2'd1));
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 1, 0, 0, 0, 0,     0, 2'd1));
      n_basic = tbl.size();
      // trigger at 0x20, four post events, then DONE; head stays 0x10
      for (int i = 0; i < 13; i++) begin
         tst = (i < 4) ? 2'd1 : (i < 8) ? 2'd2 : 2'd3;
         tbl.push_back(mk(0, 1, 32'h10 + 32'(4 * i), 32'h110 + 32'(4 * i), 1, 32'h20, 0,
                          (i < 9) ? i + 1 : 9, 1, 32'h10, 32'h110, 0, tst));
      end
      n_trig = tbl.size();

      bus.arm = 0; bus.wb_valid = 0; bus.pc_in = 0; bus.wdata_in = 0;
      bus.trig_en = 0; bus.trig_pc = 0; bus.rd_ready = 0;

      // reset state
      repeat (2) @(posedge Clk);
      #1;
      chk("rst state", 32'(bus.state), 0);
      chk("rst count", 32'(bus.count), 0);
      chk("rst rd_valid", 32'(bus.rd_valid), 0);
      chk("rst overflow", 32'(bus.overflow), 0);
      chk("rst rd_pc", bus.rd_pc, 0);
      chk("rst rd_data", bus.rd_data, 0);
      Rst = 0;

      run_rows(0, n_basic);

      // fill past capacity without reading
      for (int i = 0; i < 18; i++) cyc(0, 1, 32'h100 + 32'(4 * i), 32'(i), 0);
      chk("ovf count", 32'(bus.count), 16);
      chk("ovf flag", 32'(bus.overflow), 1);
      chk("ovf head pc", bus.rd_pc, 32'h100);
      chk("ovf head data", bus.rd_data, 0);
      cyc(1, 0, 0, 0, 0);
      chk("rearm ovf", 32'(bus.overflow), 0);
      chk("rearm count", 32'(bus.count), 16);
      chk("rearm state", 32'(bus.state), 1);

      // full FIFO: push and pop in the same edge
      cyc(0, 1, 32'h500, 32'hAA, 1);
      chk("fullpp count", 32'(bus.count), 16);
      chk("fullpp ovf", 32'(bus.overflow), 0);
      chk("fullpp head", bus.rd_pc, 32'h104);
      for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 1);
      chk("tail count", 32'(bus.count), 1);
      chk("tail pc", bus.rd_pc, 32'h500);
      chk("tail data", bus.rd_data, 32'hAA);
      cyc(0, 0, 0, 0, 1);
      chk("tail empty", 32'(bus.count), 0);

      run_rows(n_basic, n_trig);
      bus.trig_en = 0;
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("trig pop%0d pc", i), bus.rd_pc, 32'h10 + 32'(4 * i));
         cyc(0, 0, 0, 0, 1);
      end
      chk("trig drained", 32'(bus.count), 0);
      chk("trig done", 32'(bus.state), 3);

      // re-arm from DONE, then repeated PCs
      cyc(1, 0, 0, 0, 0);
      chk("done rearm", 32'(bus.state), 1);
      cyc(0, 1, 32'h8, 32'h1, 0);
      cyc(0, 1, 32'h8, 32'h2, 0);
      cyc(0, 1, 32'h8, 32'h3, 0);
      cyc(0, 1, 32'hC, 32'h4, 0);
`ifdef TRACE_DEDUP_EN
      exp_dd = 2;
`else
      exp_dd = 4;
`endif
      chk("dedup count", 32'(bus.count), 32'(exp_dd));
      chk("dedup ovf", 32'(bus.overflow), 0);
      drain("dedup drained");

      // async reset in the middle of POST with 5 entries held
      bus.trig_en = 1; bus.trig_pc = 32'h60;
      for (int i = 0; i < 5; i++) cyc(0, 1, 32'h50 + 32'(4 * i), 32'(i), 0);
      chk("post state", 32'(bus.state), 2);
      chk("post count", 32'(bus.count), 5);
      Rst = 1;
      #1;
      chk("arst state", 32'(bus.state), 0);
      chk("arst count", 32'(bus.count), 0);
      chk("arst rd_valid", 32'(bus.rd_valid), 0);
      chk("arst rd_pc", bus.rd_pc, 0);
      @(posedge Clk); #1;
      Rst = 0;
      bus.trig_en = 0;
      cyc(0, 1, 32'h70, 32'h7, 0);
      chk("idle no write", 32'(bus.count), 0);
      chk("idle state", 32'(bus.state), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
